// File: rtl/dmem_responder.sv
// Word-addressed data memory behind the core's load/store port: clears itself after
// reset, returns reads after a fixed pipeline latency, flags illegal requests, counts accesses.
module dmem_responder #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 512,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              init_done,
    output logic              err,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] init_ptr_q;
    logic              init_done_q;
    logic              err_q;
    logic [15:0]       wr_cnt_q;
    logic [15:0]       rd_cnt_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_W-1:0]       dat_q [READ_LATENCY];

    logic              ready;
    logic              rd_accept;
    logic              wr_accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    // Request qualification and the single memory write port (clear sweep or user write)
    always_comb begin
        ready     = (state_q == ST_READY);
        rd_accept = ready & rd & ~wr;
        wr_accept = ready & wr & ~rd;
        mem_we    = 1'b0;
        mem_wa    = addr;
        mem_wd    = wr_data;
        if (!ready) begin
            mem_we = 1'b1;
            mem_wa = init_ptr_q;
            mem_wd = {DATA_W{1'b0}};
        end else begin
            mem_we = wr_accept;
            mem_wa = addr;
            mem_wd = wr_data;
        end
    end

    // Storage array; no reset, the clear sweep establishes its contents
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    // Control FSM, error flag and saturating access counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_ptr_q  <= {ADDR_W{1'b0}};
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            wr_cnt_q    <= 16'd0;
            rd_cnt_q    <= 16'd0;
        end else begin
            err_q       <= ready ? (rd & wr) : (rd | wr);
            init_done_q <= ready;
            case (state_q)
                ST_INIT: begin
                    init_ptr_q <= init_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (init_ptr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= ST_READY;
                    end
                end
                ST_READY: state_q <= ST_READY;
                default:  state_q <= ST_INIT;
            endcase
            if (wr_accept && (wr_cnt_q != 16'hFFFF)) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
            if (rd_accept && (rd_cnt_q != 16'hFFFF)) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    // Read pipeline: data captured at the issue edge, then shifted; last stage holds when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= {READ_LATENCY{1'b0}};
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            vld_q[0] <= rd_accept;
            if (rd_accept) begin
                dat_q[0] <= mem_q[addr];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign rd_data   = dat_q[READ_LATENCY-1];
    assign rd_valid  = vld_q[READ_LATENCY-1];
    assign init_done = init_done_q;
    assign err       = err_q;
    assign wr_count  = wr_cnt_q;
    assign rd_count  = rd_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (read latency 1, 3, 4) share one stimulus
// stream and are checked against a queue-based scoreboard of the memory's behaviour.
module tb_dmem_responder;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 512;
    localparam int NK    = 3;
    localparam int LAT [NK] = '{1, 3, 4};

    logic          clk = 1'b0;
    logic          reset, wr, rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] rd_data_w  [NK];
    logic          rd_valid_w [NK];
    logic          init_done_w[NK];
    logic          err_w      [NK];
    logic [15:0]   wr_cnt_w   [NK];
    logic [15:0]   rd_cnt_w   [NK];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .READ_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data_w[0]), .rd_valid(rd_valid_w[0]), .init_done(init_done_w[0]),
        .err(err_w[0]), .wr_count(wr_cnt_w[0]), .rd_count(rd_cnt_w[0]));

    dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .READ_LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data_w[1]), .rd_valid(rd_valid_w[1]), .init_done(init_done_w[1]),
        .err(err_w[1]), .wr_count(wr_cnt_w[1]), .rd_count(rd_cnt_w[1]));

    dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .READ_LATENCY(4)) u_dut_l4 (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data_w[2]), .rd_valid(rd_valid_w[2]), .init_done(init_done_w[2]),
        .err(err_w[2]), .wr_count(wr_cnt_w[2]), .rd_count(rd_cnt_w[2]));

    // Reference model: array memory, ready after DEPTH clean edges, per-latency result queues
    typedef struct {
        longint        due;
        logic [DW-1:0] data;
    } rd_t;

    longint        cyc = 0;
    logic [DW-1:0] m_mem [DEPTH];
    int            m_init_cnt = 0;
    bit            m_init_done = 1'b0;
    bit            m_err = 1'b0;
    int            m_wr_cnt = 0;
    int            m_rd_cnt = 0;
    rd_t           m_q [NK][$];
    bit            m_vld [NK];
    logic [DW-1:0] m_dat [NK];

    task automatic step(input bit r, input bit w_i, input bit rd_i,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit  rdy;
        rd_t e;
        reset = r; wr = w_i; rd = rd_i; addr = a; wr_data = d;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_init_cnt = 0; m_init_done = 1'b0; m_err = 1'b0;
            m_wr_cnt = 0; m_rd_cnt = 0;
            for (int k = 0; k < NK; k++) begin
                m_q[k].delete(); m_vld[k] = 1'b0; m_dat[k] = '0;
            end
        end else begin
            rdy = (m_init_cnt >= DEPTH);
            m_err = rdy ? (w_i && rd_i) : (w_i || rd_i);
            m_init_done = rdy;
            if (!rdy) begin
                m_init_cnt++;
                if (m_init_cnt == DEPTH) begin
                    for (int j = 0; j < DEPTH; j++) m_mem[j] = '0;
                end
            end else if (rd_i && !w_i) begin
                if (m_rd_cnt < 65535) m_rd_cnt++;
                for (int k = 0; k < NK; k++) begin
                    e.due = cyc + longint'(LAT[k]) - 1;
                    e.data = m_mem[a];
                    m_q[k].push_back(e);
                end
            end else if (w_i && !rd_i) begin
                m_mem[a] = d;
                if (m_wr_cnt < 65535) m_wr_cnt++;
            end
            for (int k = 0; k < NK; k++) begin
                if (m_q[k].size() > 0 && m_q[k][0].due == cyc) begin
                    m_vld[k] = 1'b1;
                    m_dat[k] = m_q[k][0].data;
                    void'(m_q[k].pop_front());
                end else begin
                    m_vld[k] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < NK; k++) begin
            total++;
            if (rd_valid_w[k] !== 1'b0 || rd_data_w[k] !== 32'h0 || init_done_w[k] !== 1'b0 ||
                err_w[k] !== 1'b0 || wr_cnt_w[k] !== 16'd0 || rd_cnt_w[k] !== 16'd0) begin
                bad++;
                $display("FAIL reset k=%0d got vld=%b data=%h done=%b err=%b wc=%0d rc=%0d required all zero",
                         k, rd_valid_w[k], rd_data_w[k], init_done_w[k], err_w[k], wr_cnt_w[k], rd_cnt_w[k]);
            end
        end
    endtask

    // Clear sweep timing, write lost during INIT, then read of a never-written word
    task automatic test_post_reset_clear();
        logic [DW-1:0] exp_d [2];
        exp_d[0] = 32'h0; exp_d[1] = 32'h0;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            step(1'b0, (i == 10), 1'b0, 9'd20, 32'hABCD0123);
            if (i == 10 || i == 11) begin
                for (int k = 0; k < NK; k++) begin
                    total++;
                    if (err_w[k] !== (i == 10)) begin
                        bad++;
                        $display("FAIL init_write_err k=%0d edge=%0d got=%b required=%b", k, i, err_w[k], (i == 10));
                    end
                end
            end
            if (i == DEPTH || i == DEPTH + 1) begin
                for (int k = 0; k < NK; k++) begin
                    total++;
                    if (init_done_w[k] !== (i == DEPTH + 1)) begin
                        bad++;
                        $display("FAIL init_done_edge k=%0d edge=%0d got=%b required=%b",
                                 k, i, init_done_w[k], (i == DEPTH + 1));
                    end
                end
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 6; c++) begin
                step(1'b0, 1'b0, (c == 0), (r == 0) ? 9'd300 : 9'd20, '0);
                for (int k = 0; k < NK; k++) begin
                    total++;
                    if (rd_valid_w[k] !== (c == LAT[k] - 1) ||
                        (c == LAT[k] - 1 && rd_data_w[k] !== exp_d[r])) begin
                        bad++;
                        $display("FAIL clear_read k=%0d r=%0d c=%0d got vld=%b data=%h required vld=%b data=%h",
                                 k, r, c, rd_valid_w[k], rd_data_w[k], (c == LAT[k] - 1), exp_d[r]);
                    end
                end
            end
        end
        for (int k = 0; k < NK; k++) begin
            total++;
            if (rd_cnt_w[k] !== 16'd2 || wr_cnt_w[k] !== 16'd0) begin
                bad++;
                $display("FAIL clear_counts k=%0d got rc=%0d wc=%0d required rc=2 wc=0", k, rd_cnt_w[k], wr_cnt_w[k]);
            end
        end
    endtask

    // Write then immediate read, and three back-to-back pipelined reads
    task automatic test_write_read_pipelined();
        logic [DW-1:0] exp_d [3];
        exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33;
        step(1'b0, 1'b1, 1'b0, 9'd5, 32'hDEADBEEF);
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 1'b0, (c == 0), 9'd5, '0);
            for (int k = 0; k < NK; k++) begin
                total++;
                if (rd_valid_w[k] !== (c == LAT[k] - 1) ||
                    (c == LAT[k] - 1 && rd_data_w[k] !== 32'hDEADBEEF)) begin
                    bad++;
                    $display("FAIL write_read k=%0d c=%0d got vld=%b data=%h required vld=%b data=deadbeef",
                             k, c, rd_valid_w[k], rd_data_w[k], (c == LAT[k] - 1));
                end
            end
        end
        for (int k = 0; k < NK; k++) begin
            total++;
            if (wr_cnt_w[k] !== 16'd1 || rd_cnt_w[k] !== 16'd3) begin
                bad++;
                $display("FAIL write_read_counts k=%0d got wc=%0d rc=%0d required wc=1 rc=3", k, wr_cnt_w[k], rd_cnt_w[k]);
            end
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, AW'(i + 1), exp_d[i]);
        for (int c = 0; c < 9; c++) begin
            step(1'b0, 1'b0, (c < 3), AW'(c + 1), '0);
            for (int k = 0; k < NK; k++) begin
                automatic int  slot = c - (LAT[k] - 1);
                automatic bit  ev   = (slot >= 0 && slot < 3);
                total++;
                if (rd_valid_w[k] !== ev || (ev && rd_data_w[k] !== exp_d[slot])) begin
                    bad++;
                    $display("FAIL pipelined k=%0d c=%0d got vld=%b data=%h required vld=%b", k, c, rd_valid_w[k], rd_data_w[k], ev);
                end
            end
        end
    endtask

    // Simultaneous wr and rd: error pulse, no access, counters frozen
    task automatic test_illegal();
        step(1'b0, 1'b1, 1'b0, 9'd7, 32'h77);
        step(1'b0, 1'b1, 1'b1, 9'd7, 32'h55);
        for (int k = 0; k < NK; k++) begin
            total++;
            if (err_w[k] !== 1'b1 || wr_cnt_w[k] !== 16'(m_wr_cnt) || rd_cnt_w[k] !== 16'(m_rd_cnt)) begin
                bad++;
                $display("FAIL illegal_err k=%0d got err=%b wc=%0d rc=%0d required err=1 wc=%0d rc=%0d",
                         k, err_w[k], wr_cnt_w[k], rd_cnt_w[k], m_wr_cnt, m_rd_cnt);
            end
        end
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 1'b0, (c == 0), 9'd7, '0);
            for (int k = 0; k < NK; k++) begin
                total++;
                if ((c == 0 && err_w[k] !== 1'b0) || rd_valid_w[k] !== (c == LAT[k] - 1) ||
                    (c == LAT[k] - 1 && rd_data_w[k] !== 32'h77)) begin
                    bad++;
                    $display("FAIL illegal_read k=%0d c=%0d got vld=%b data=%h err=%b required data=77",
                             k, c, rd_valid_w[k], rd_data_w[k], err_w[k]);
                end
            end
        end
    endtask

    // Random traffic over a small address window to exercise hazards
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            automatic int op = $urandom_range(0, 9);
            step(1'b0, (op >= 4 && op <= 7), (op <= 3 || op == 7), AW'($urandom_range(0, 15)), DW'($urandom));
            for (int k = 0; k < NK; k++) begin
                total++;
                if (rd_valid_w[k] !== m_vld[k] || rd_data_w[k] !== m_dat[k] || err_w[k] !== m_err ||
                    wr_cnt_w[k] !== 16'(m_wr_cnt) || rd_cnt_w[k] !== 16'(m_rd_cnt) || init_done_w[k] !== m_init_done) begin
                    bad++;
                    $display("FAIL random k=%0d i=%0d got vld=%b data=%h err=%b wc=%0d rc=%0d required vld=%b data=%h err=%b wc=%0d rc=%0d",
                             k, i, rd_valid_w[k], rd_data_w[k], err_w[k], wr_cnt_w[k], rd_cnt_w[k],
                             m_vld[k], m_dat[k], m_err, m_wr_cnt, m_rd_cnt);
                end
            end
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Reset two cycles after a read: result discarded, sweep restarts
    task automatic test_reset_midflight();
        step(1'b0, 1'b1, 1'b0, 9'd9, 32'h99);
        step(1'b0, 1'b0, 1'b1, 9'd9, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < NK; k++) begin
            total++;
            if (init_done_w[k] !== 1'b0 || wr_cnt_w[k] !== 16'd0 || rd_cnt_w[k] !== 16'd0 || rd_valid_w[k] !== 1'b0) begin
                bad++;
                $display("FAIL midflight_reset k=%0d got done=%b wc=%0d rc=%0d vld=%b required all zero",
                         k, init_done_w[k], wr_cnt_w[k], rd_cnt_w[k], rd_valid_w[k]);
            end
        end
        for (int i = 1; i <= DEPTH + 1; i++) begin
            step(1'b0, 1'b0, 1'b0, '0, '0);
            for (int k = 0; k < NK; k++) begin
                if (i <= 4 || i == DEPTH || i == DEPTH + 1) begin
                    total++;
                    if (rd_valid_w[k] !== 1'b0 || init_done_w[k] !== (i == DEPTH + 1)) begin
                        bad++;
                        $display("FAIL midflight_sweep k=%0d edge=%0d got vld=%b done=%b required vld=0 done=%b",
                                 k, i, rd_valid_w[k], init_done_w[k], (i == DEPTH + 1));
                    end
                end
            end
        end
    endtask

    // Write counter must stick at its maximum
    task automatic test_saturation();
        for (int i = 1; i <= 65540; i++) begin
            step(1'b0, 1'b1, 1'b0, AW'(i), DW'(i));
            if (i == 65534 || i == 65535 || i == 65540) begin
                for (int k = 0; k < NK; k++) begin
                    automatic logic [15:0] exp_wc = (i == 65534) ? 16'hFFFE : 16'hFFFF;
                    total++;
                    if (wr_cnt_w[k] !== exp_wc || rd_cnt_w[k] !== 16'd0) begin
                        bad++;
                        $display("FAIL saturation k=%0d n=%0d got wc=%h rc=%h required wc=%h rc=0000",
                                 k, i, wr_cnt_w[k], rd_cnt_w[k], exp_wc);
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0;
        #2;
        test_reset();
        test_post_reset_clear();
        test_write_read_pipelined();
        test_illegal();
        test_random();
        test_reset_midflight();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
